// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch and next-PC stage of the single-cycle MIPS core.
// Owns the PC, fetches over a req/ack port, holds the instruction for decode and
// picks the next PC from the control_unit jump/branch decisions and the ALU zero flag.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | one-cycle pause after reset; late acks are ignored here
// FETCH | request held at PC, waiting for ack; timeout counter runs
// EXEC  | instruction valid for decode; retires when not stalled
// ERR   | fetch timed out; request dropped until reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic [5:0]  o_opCode,
  output logic        o_instr_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  input  logic        i_jump,
  input  logic        i_br_beq,
  input  logic        i_br_bne,
  input  logic        i_zero,
  output logic        o_retire,
  output logic        o_fetch_err
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_instr;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  logic          w_load_instr;
  logic          w_cnt_inc;
  logic          w_cnt_clr;
  logic          w_set_err;
  logic          w_pc_upd;

  logic [31:0]   w_seq;
  logic [31:0]   w_brt;
  logic [31:0]   w_jmp;
  logic [31:0]   w_next_pc;
  logic          w_taken;

  // Next-PC candidates; all sums wrap modulo 2^32 naturally.
  assign w_seq     = r_pc + 32'd4;
  assign w_brt     = w_seq + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_jmp     = {w_seq[31:28], r_instr[25:0], 2'b00};
  assign w_taken   = (i_br_beq & i_zero) | (i_br_bne & ~i_zero);
  assign w_next_pc = i_jump ? w_jmp : (w_taken ? w_brt : w_seq);

  assign o_imem_addr = r_pc;
  assign o_instr     = r_instr;
  assign o_opCode    = r_instr[31:26];
  assign o_pc        = r_pc;
  assign o_pc_plus4  = w_seq;
  assign o_fetch_err = r_err;

  // Next-state and per-state strobes.
  always_comb begin
    w_next_state  = r_state;
    o_imem_req    = 1'b0;
    o_instr_valid = 1'b0;
    o_retire      = 1'b0;
    w_load_instr  = 1'b0;
    w_cnt_inc     = 1'b0;
    w_cnt_clr     = 1'b0;
    w_set_err     = 1'b0;
    w_pc_upd      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next_state = S_FETCH;
      end
      S_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          // An ack on the final allowed cycle still wins over the timeout.
          w_load_instr = 1'b1;
          w_cnt_clr    = 1'b1;
          w_next_state = S_EXEC;
        end else if (r_cnt == CNT_LAST) begin
          w_set_err    = 1'b1;
          w_next_state = S_ERR;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_EXEC: begin
        o_instr_valid = 1'b1;
        if (!i_stall) begin
          o_retire     = 1'b1;
          w_pc_upd     = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_ERR: begin
        w_next_state = S_ERR;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, PC, instruction register, timeout counter and sticky error flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_pc    <= {RESET_PC[31:2], 2'b00};
      r_instr <= 32'd0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_load_instr) r_instr <= i_imem_rdata;
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CW'(1);
      if (w_pc_upd)  r_pc  <= w_next_pc;
      if (w_set_err) r_err <= 1'b1;
    end
  end

endmodule
